// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/bubble sequencer.
// Holds the FSM state type, the stage indices and the per-register control bundle.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } pc_state_t;

    localparam int IF_ID  = 0;
    localparam int ID_EX  = 1;
    localparam int EX_MEM = 2;
    localparam int MEM_WB = 3;

    typedef struct packed {
        logic stall;
        logic bubble;
    } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Ports: clk, rst_n, inc (count enable), count (current value, sticks at all-ones).
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Stall/bubble sequencer for the five-stage pipeline, with stale-fetch discard tracking.
// Ports: memory handshakes, hazard and branch flags in; pc_load, per-register stall/bubble and perf counters out.
module pipeline_control
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 ex_busy,
    input  logic                 load_use,
    input  logic                 branch_taken,
    output logic                 pc_load,
    output logic                 stall_if_id,
    output logic                 stall_id_ex,
    output logic                 stall_ex_mem,
    output logic                 stall_mem_wb,
    output logic                 bubble_if_id,
    output logic                 bubble_id_ex,
    output logic                 bubble_ex_mem,
    output logic                 bubble_mem_wb,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    pc_state_t         state_q;
    pc_state_t         state_d;
    stage_ctrl_t [3:0] ctrl;
    logic              dmem_wait;
    logic              imem_wait;
    logic              stall_inc;
    logic              flush_inc;

    assign dmem_wait = dmem_req & ~dmem_resp;
    assign imem_wait = imem_req & ~imem_resp;

    always_comb begin
        state_d   = state_q;
        pc_load   = 1'b1;
        ctrl      = '0;
        flush_inc = 1'b0;

        if (!rst_n) begin
            pc_load = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ctrl[i].bubble = 1'b1;
            end
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (dmem_wait) begin
                pc_load              = 1'b0;
                ctrl[IF_ID].stall    = 1'b1;
                ctrl[ID_EX].stall    = 1'b1;
                ctrl[EX_MEM].stall   = 1'b1;
                ctrl[MEM_WB].bubble  = 1'b1;
            end else if (branch_taken) begin
                ctrl[IF_ID].bubble   = 1'b1;
                ctrl[ID_EX].bubble   = 1'b1;
                ctrl[EX_MEM].bubble  = 1'b1;
                flush_inc            = 1'b1;
                // A response landing now is killed by the if_id bubble;
                // only a still-pending fetch needs tracking.
                if (imem_wait) begin
                    state_d = DISCARD;
                end
            end else if (ex_busy) begin
                pc_load              = 1'b0;
                ctrl[IF_ID].stall    = 1'b1;
                ctrl[ID_EX].stall    = 1'b1;
                ctrl[EX_MEM].bubble  = 1'b1;
            end else if (load_use) begin
                pc_load              = 1'b0;
                ctrl[IF_ID].stall    = 1'b1;
                ctrl[ID_EX].bubble   = 1'b1;
            end else if (imem_wait) begin
                pc_load              = 1'b0;
                ctrl[IF_ID].bubble   = 1'b1;
            end
        end else begin
            // if_id only ever holds NOPs here, so it is bubbled rather
            // than stalled; downstream hazards act on later stages only.
            pc_load            = 1'b0;
            ctrl[IF_ID].bubble = 1'b1;
            if (dmem_wait) begin
                ctrl[ID_EX].stall    = 1'b1;
                ctrl[EX_MEM].stall   = 1'b1;
                ctrl[MEM_WB].bubble  = 1'b1;
            end else if (branch_taken) begin
                pc_load              = 1'b1;
                ctrl[ID_EX].bubble   = 1'b1;
                ctrl[EX_MEM].bubble  = 1'b1;
                flush_inc            = 1'b1;
            end else if (ex_busy) begin
                ctrl[ID_EX].stall    = 1'b1;
                ctrl[EX_MEM].bubble  = 1'b1;
            end else if (load_use) begin
                ctrl[ID_EX].bubble   = 1'b1;
            end
            if (imem_resp) begin
                state_d = RUN;
            end
        end
    end

    assign stall_inc = rst_n & ~pc_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_if_id   = ctrl[IF_ID].stall;
    assign stall_id_ex   = ctrl[ID_EX].stall;
    assign stall_ex_mem  = ctrl[EX_MEM].stall;
    assign stall_mem_wb  = ctrl[MEM_WB].stall;
    assign bubble_if_id  = ctrl[IF_ID].bubble;
    assign bubble_id_ex  = ctrl[ID_EX].bubble;
    assign bubble_ex_mem = ctrl[EX_MEM].bubble;
    assign bubble_mem_wb = ctrl[MEM_WB].bubble;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed scenarios then random traffic.
// Expected values come from a rule-level model of stage boundaries and counters.
module tb_pipeline_control;

    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req, imem_resp, dmem_req, dmem_resp;
    logic          ex_busy, load_use, branch_taken;
    logic          pc_load;
    logic          stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic          bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_pass  = 0;
    int n_total = 0;

    bit m_disc;
    int m_sc;
    int m_fc;

    always #5 clk = ~clk;

    pipeline_control #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_resp     (imem_resp),
        .dmem_req      (dmem_req),
        .dmem_resp     (dmem_resp),
        .ex_busy       (ex_busy),
        .load_use      (load_use),
        .branch_taken  (branch_taken),
        .pc_load       (pc_load),
        .stall_if_id   (stall_if_id),
        .stall_id_ex   (stall_id_ex),
        .stall_ex_mem  (stall_ex_mem),
        .stall_mem_wb  (stall_mem_wb),
        .bubble_if_id  (bubble_if_id),
        .bubble_id_ex  (bubble_id_ex),
        .bubble_ex_mem (bubble_ex_mem),
        .bubble_mem_wb (bubble_mem_wb),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input bit r, input bit ir, input bit is,
                         input bit dr, input bit ds, input bit eb,
                         input bit lu, input bit br);
        rst_n = r; imem_req = ir; imem_resp = is;
        dmem_req = dr; dmem_resp = ds;
        ex_busy = eb; load_use = lu; branch_taken = br;
    endtask

    function automatic int sat(input int v);
        return (v + 1 > MAXC) ? MAXC : v + 1;
    endfunction

    // Hazard rules pick one register boundary k: every register upstream
    // of k holds, k receives a NOP. A redirect squashes the three upstream
    // registers. While discarding, if_id is a permanent NOP sink.
    task automatic cycle(input string tag);
        bit       dw, iw, pc, acc;
        bit [3:0] st, bu;
        int       k;
        #2;
        check({tag, ":stall_cycles"}, 32'(stall_cycles), m_sc);
        check({tag, ":flush_count"}, 32'(flush_count), m_fc);
        dw  = dmem_req & ~dmem_resp;
        iw  = imem_req & ~imem_resp;
        acc = branch_taken & ~dw;
        pc  = 1'b0;
        st  = '0;
        bu  = '0;
        if (!rst_n) begin
            bu = 4'hf;
        end else begin
            k = -1;
            if (dw) k = 3;
            else if (!branch_taken) begin
                if (ex_busy) k = 2;
                else if (load_use) k = 1;
                else if (!m_disc && iw) k = 0;
            end
            if (acc) begin
                pc = 1'b1;
                bu = 4'b0111;
            end else begin
                pc = !m_disc && (k < 0);
            end
            if (k >= 0) begin
                bu[k] = 1'b1;
                for (int i = 0; i < k; i++) st[i] = 1'b1;
            end
            if (m_disc) begin
                st[0] = 1'b0;
                bu[0] = 1'b1;
            end
        end
        check({tag, ":ctrl"},
              32'({pc_load, stall_mem_wb, stall_ex_mem, stall_id_ex,
                   stall_if_id, bubble_mem_wb, bubble_ex_mem,
                   bubble_id_ex, bubble_if_id}),
              32'({pc, st, bu}));
        @(posedge clk);
        if (!rst_n) begin
            m_disc = 1'b0;
            m_sc   = 0;
            m_fc   = 0;
        end else begin
            if (!pc) m_sc = sat(m_sc);
            if (acc) m_fc = sat(m_fc);
            if (m_disc) m_disc = ~imem_resp;
            else m_disc = acc & iw;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rst");
    endtask

    initial begin
        m_disc = 1'b0;
        m_sc   = 0;
        m_fc   = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);

        // reset held, then released idle
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_pc_load", 32'(pc_load), 0);
            check("rst_bubbles", 32'({bubble_if_id, bubble_id_ex,
                                      bubble_ex_mem, bubble_mem_wb}), 32'hf);
            cycle("reset_hold");
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("idle_pc_load", 32'(pc_load), 1);
        cycle("idle");
        check("idle_cnt", 32'({stall_cycles, flush_count}), 0);

        // branch held behind a data-memory wait
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 0, 0, 0, 1);
            cycle("dwait_br");
        end
        drive(1, 0, 0, 1, 1, 0, 0, 1);
        #1;
        check("dresp_br_pc", 32'(pc_load), 1);
        cycle("dresp_br");
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycle("idle");
        check("dwait_sc", 32'(stall_cycles), 4);
        check("dwait_fc", 32'(flush_count), 1);

        // redirect with fetch in flight
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        cycle("br_iwait");
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("disc_pc", 32'(pc_load), 0);
        cycle("discard");
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        #1;
        check("disc_resp_bub", 32'(bubble_if_id), 1);
        cycle("discard_resp");
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        #1;
        check("refetch_pc", 32'(pc_load), 1);
        cycle("refetch");

        // single load-use hazard
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        #1;
        check("lu_ctrl", 32'({stall_if_id, bubble_id_ex, pc_load}), 32'b110);
        cycle("load_use");
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycle("idle");
        check("lu_sc", 32'(stall_cycles), 1);

        // ex_busy beats load_use
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 0);
            #1;
            check("busy_wins", 32'({bubble_ex_mem, bubble_id_ex}), 32'b10);
            cycle("busy_lu");
        end

        // stall counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            cycle("iwait_sat");
        end
        check("sat_sc", 32'(stall_cycles), 15);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(39) != 0,
                  $urandom_range(99) < 60, $urandom_range(99) < 40,
                  $urandom_range(99) < 30, $urandom_range(99) < 50,
                  $urandom_range(99) < 15, $urandom_range(99) < 15,
                  $urandom_range(99) < 12);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
